// File: rtl/lvds_tx.sv
// Serializes 32-bit I/Q frames from the TX FIFO into 2-bit DDR pairs, MSB pair first.
// Frames are 16 clocks; enable/FIFO decisions happen at phase 14, loads at the 15->0 boundary.
module lvds_tx #(
  parameter int unsigned UNDERRUN_W = 8,
  parameter logic [31:0] IDLE_FRAME = 32'h8000_4000
) (
  input  logic                  i_ddr_clk,
  input  logic                  i_rst,
  input  logic                  i_tx_en,
  input  logic                  i_fifo_empty,
  output logic                  o_fifo_pull,
  input  logic [31:0]           i_fifo_data,
  output logic [1:0]            o_ddr_data,
  output logic                  o_busy,
  output logic                  o_frame_start,
  input  logic                  i_clr_underrun,
  output logic [UNDERRUN_W-1:0] o_underrun_cnt
);

  localparam logic [3:0]            PH_DECIDE = 4'd14;
  localparam logic [3:0]            PH_LAST   = 4'd15;
  localparam logic [31:0]           SYNC_KEEP = 32'h3FFF_3FFF;
  localparam logic [31:0]           SYNC_BITS = 32'h8000_4000;
  localparam logic [UNDERRUN_W-1:0] CNT_MAX   = '1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state;
  logic [3:0]  r_phase;
  logic [31:0] r_sreg;
  logic        r_en;
  logic        r_pulled;

  // Phase counter, frame decision, shift register and underrun counter.
  always_ff @(posedge i_ddr_clk) begin
    if (i_rst) begin
      state          <= IDLE;
      r_phase        <= 4'd0;
      r_sreg         <= 32'h0;
      r_en           <= 1'b0;
      r_pulled       <= 1'b0;
      o_fifo_pull    <= 1'b0;
      o_frame_start  <= 1'b1;
      o_underrun_cnt <= '0;
    end else begin
      r_phase       <= r_phase + 4'd1;
      o_frame_start <= (r_phase == PH_LAST);
      o_fifo_pull   <= 1'b0;

      if (r_phase == PH_DECIDE) begin
        r_en        <= i_tx_en;
        r_pulled    <= i_tx_en & ~i_fifo_empty;
        o_fifo_pull <= i_tx_en & ~i_fifo_empty;
      end

      if (r_phase == PH_LAST) begin
        state <= r_en ? RUN : IDLE;
        if (!r_en)
          r_sreg <= 32'h0;
        else if (r_pulled)
          r_sreg <= (i_fifo_data & SYNC_KEEP) | SYNC_BITS;
        else
          r_sreg <= IDLE_FRAME;
      end else begin
        r_sreg <= {r_sreg[29:0], 2'b00};
      end

      // Clear wins over a same-cycle increment; the count saturates at all-ones.
      if (i_clr_underrun)
        o_underrun_cnt <= '0;
      else if ((r_phase == PH_LAST) && r_en && !r_pulled && (o_underrun_cnt != CNT_MAX))
        o_underrun_cnt <= o_underrun_cnt + UNDERRUN_W'(1);
    end
  end

  assign o_ddr_data = r_sreg[31:30];
  assign o_busy     = (state == RUN);

endmodule

// File: tb/tb_lvds_tx.sv
// Scoreboard bench for lvds_tx: expected pairs are queued at each phase-14 decision
// and popped/compared every clock against the DUT output.
module tb_lvds_tx;

  logic        i_ddr_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_tx_en = 1'b0;
  logic        i_fifo_empty = 1'b1;
  logic        o_fifo_pull;
  logic [31:0] i_fifo_data = 32'h0;
  logic [1:0]  o_ddr_data;
  logic        o_busy;
  logic        o_frame_start;
  logic        i_clr_underrun = 1'b0;
  logic [7:0]  o_underrun_cnt;

  lvds_tx dut (
    .i_ddr_clk      (i_ddr_clk),
    .i_rst          (i_rst),
    .i_tx_en        (i_tx_en),
    .i_fifo_empty   (i_fifo_empty),
    .o_fifo_pull    (o_fifo_pull),
    .i_fifo_data    (i_fifo_data),
    .o_ddr_data     (o_ddr_data),
    .o_busy         (o_busy),
    .o_frame_start  (o_frame_start),
    .i_clr_underrun (i_clr_underrun),
    .o_underrun_cnt (o_underrun_cnt)
  );

  initial forever #5 i_ddr_clk = ~i_ddr_clk;

  typedef struct packed {
    logic [1:0] ddr;
    logic       busy;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] fifo_q[$];
  int          tests = 0;
  int          failed = 0;
  int          ph = 0;
  int          cnt = 0;
  logic        exp_pull = 1'b0;
  logic        pend_under = 1'b0;
  logic        pull_prev = 1'b0;
  logic [31:0] cap;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      failed++;
      $error("FAIL %s at t=%0t: observed %0h expected %0h", tag, $time, obs, expv);
    end
  endtask

  // FWFT FIFO model: head word is always presented while non-empty.
  task automatic fifo_drive();
    i_fifo_empty = (fifo_q.size() == 0);
    i_fifo_data  = (fifo_q.size() == 0) ? 32'h0 : fifo_q[0];
  endtask

  task automatic fifo_push(input logic [31:0] w);
    fifo_q.push_back(w);
    fifo_drive();
  endtask

  task automatic push_frame(input logic [31:0] w, input logic busy);
    exp_t e;
    logic [31:0] t;
    t = w;
    for (int i = 0; i < 16; i++) begin
      e.ddr  = t[31:30];
      e.busy = busy;
      exp_q.push_back(e);
      t = t << 2;
    end
  endtask

  task automatic check_cycle();
    exp_t e;
    if (exp_q.size() == 0) begin
      tests++;
      failed++;
      $error("FAIL scoreboard_empty at t=%0t: observed 0 entries expected >0", $time);
    end else begin
      e = exp_q.pop_front();
      chk("ddr_data", 32'(o_ddr_data), 32'(e.ddr));
      chk("busy", 32'(o_busy), 32'(e.busy));
    end
    chk("frame_start", 32'(o_frame_start), 32'(ph == 0));
    chk("fifo_pull", 32'(o_fifo_pull), 32'((ph == 15) && exp_pull));
    chk("underrun_cnt", 32'(o_underrun_cnt), 32'(cnt));
    pull_prev = o_fifo_pull;
  endtask

  task automatic tick();
    logic        clr;
    logic        inc;
    logic [31:0] w;
    clr = i_clr_underrun;
    inc = (ph == 15) && pend_under;
    if (ph == 14) begin
      exp_pull   = i_tx_en && !i_fifo_empty;
      pend_under = i_tx_en && i_fifo_empty;
      if (!i_tx_en)      w = 32'h0;
      else if (exp_pull) w = {2'b10, fifo_q[0][29:16], 2'b01, fifo_q[0][13:0]};
      else               w = 32'h8000_4000;
      push_frame(w, i_tx_en);
    end
    @(posedge i_ddr_clk);
    if (pull_prev && fifo_q.size() > 0) void'(fifo_q.pop_front());
    ph = (ph + 1) % 16;
    if (clr)                  cnt = 0;
    else if (inc && cnt < 255) cnt = cnt + 1;
    #1;
    fifo_drive();
    check_cycle();
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    @(posedge i_ddr_clk);
    #1;
    i_rst = 1'b0;
    ph = 0;
    cnt = 0;
    exp_pull = 1'b0;
    pend_under = 1'b0;
    pull_prev = 1'b0;
    exp_q.delete();
    push_frame(32'h0, 1'b0);
    fifo_drive();
    check_cycle();
  endtask

  task automatic run_to_phase(input int p);
    tick();
    for (int i = 0; i < 16 && ph != p; i++) tick();
  endtask

  task automatic capture_frame(output logic [31:0] w);
    w = 32'h0;
    for (int i = 0; i < 16; i++) begin
      tick();
      w = {w[29:0], o_ddr_data};
    end
  endtask

  initial begin
    // Reset and disabled idle: 48 clocks of zeros, no pulls.
    do_reset();
    for (int i = 0; i < 47; i++) tick();
    run_to_phase(0);

    // Two data frames back to back.
    fifo_push(32'hBFFF_7FFE);
    fifo_push(32'h1234_5678);
    i_tx_en = 1'b1;
    run_to_phase(15);
    capture_frame(cap);
    chk("frame1_word", cap, 32'hBFFF_7FFE);
    i_tx_en = 1'b0;
    capture_frame(cap);
    chk("frame2_word", cap, 32'h9234_5678);
    run_to_phase(0);

    // Three underrun frames, word arrives at phase 15 of the third decision.
    i_clr_underrun = 1'b1;
    tick();
    i_clr_underrun = 1'b0;
    i_tx_en = 1'b1;
    run_to_phase(15);
    run_to_phase(15);
    run_to_phase(15);
    fifo_push(32'h0123_CDEF);
    run_to_phase(15);
    i_tx_en = 1'b0;
    capture_frame(cap);
    chk("after_underrun_word", cap, 32'h8123_4DEF);
    chk("underrun_cnt_3", 32'(o_underrun_cnt), 32'd3);
    run_to_phase(0);

    // Enable toggled mid-frame has no effect until phase 14.
    fifo_push(32'h5A5A_A5A5);
    fifo_push(32'h3C3C_C3C3);
    i_tx_en = 1'b1;
    run_to_phase(0);
    run_to_phase(5);
    i_tx_en = 1'b0;
    run_to_phase(14);
    i_tx_en = 1'b1;
    tick();
    i_tx_en = 1'b0;
    capture_frame(cap);
    chk("toggle_word", cap, 32'hBC3C_43C3);
    run_to_phase(0);

    // Reset at phase 8 of a data frame, then clean restart.
    fifo_push(32'h7777_1111);
    fifo_push(32'h2468_ACE0);
    i_tx_en = 1'b1;
    run_to_phase(0);
    run_to_phase(8);
    do_reset();
    chk("rst_ddr", 32'(o_ddr_data), 32'd0);
    chk("rst_pull", 32'(o_fifo_pull), 32'd0);
    run_to_phase(15);
    i_tx_en = 1'b0;
    capture_frame(cap);
    chk("restart_word", cap, 32'hA468_6CE0);
    run_to_phase(0);

    // Saturation with a clear landing on an increment edge.
    i_tx_en = 1'b1;
    run_to_phase(15);
    run_to_phase(15);
    run_to_phase(15);
    i_clr_underrun = 1'b1;
    tick();
    i_clr_underrun = 1'b0;
    chk("cnt_after_clear", 32'(o_underrun_cnt), 32'd0);
    for (int i = 0; i < 258; i++) run_to_phase(0);
    chk("cnt_saturated", 32'(o_underrun_cnt), 32'd255);
    i_tx_en = 1'b0;
    run_to_phase(0);
    run_to_phase(0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
